vga_layer_compositor: RTL and testbench

//  Parametrised VGA scan-out engine for the game display. Generates H/V sync and composites
//  NUM_BLOCKS rectangular obstacles, one player square and a background colour into RGB.

---
 rtl/vga_layer_compositor_if.sv | 50 +++++
 rtl/vga_layer_compositor.sv | 209 ++++++++++++++++++++
 tb/tb_vga_layer_compositor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_layer_compositor_if.sv
// vga_layer_compositor_if: game-state inputs and VGA outputs of vga_layer_compositor
// master: game logic / board side, drives i_* and samples o_*.
// slave : the compositor.
// Signals:
//   i_enable                              start/keep scanning
//   i_blk_x/y/w/h [NUM_BLOCKS*COORD_W]    block i at [i*COORD_W +: COORD_W]
//   i_blk_rgb [NUM_BLOCKS*RGB_W], i_blk_valid [NUM_BLOCKS]
//   i_sq_y, i_sq_size [COORD_W], i_sq_rgb, i_bg_rgb [RGB_W]
//   o_h_sync, o_v_sync (active low), o_rgb [RGB_W], o_frame_start
//   o_collision                           only when COLLISION_DETECT_EN is defined
interface vga_layer_compositor_if #(
  parameter int NUM_BLOCKS = 4,
  parameter int COORD_W    = 10,
  parameter int RGB_W      = 12
);
  logic                          i_enable;
  logic [NUM_BLOCKS*COORD_W-1:0] i_blk_x;
  logic [NUM_BLOCKS*COORD_W-1:0] i_blk_y;
  logic [NUM_BLOCKS*COORD_W-1:0] i_blk_w;
  logic [NUM_BLOCKS*COORD_W-1:0] i_blk_h;
  logic [NUM_BLOCKS*RGB_W-1:0]   i_blk_rgb;
  logic [NUM_BLOCKS-1:0]         i_blk_valid;
  logic [COORD_W-1:0]            i_sq_y;
  logic [COORD_W-1:0]            i_sq_size;
  logic [RGB_W-1:0]              i_sq_rgb;
  logic [RGB_W-1:0]              i_bg_rgb;
  logic                          o_h_sync;
  logic                          o_v_sync;
  logic [RGB_W-1:0]              o_rgb;
  logic                          o_frame_start;
`ifdef COLLISION_DETECT_EN
  logic                          o_collision;
`endif
  modport master (
    output i_enable, i_blk_x, i_blk_y, i_blk_w, i_blk_h, i_blk_rgb, i_blk_valid,
           i_sq_y, i_sq_size, i_sq_rgb, i_bg_rgb,
    input  o_h_sync, o_v_sync, o_rgb, o_frame_start
`ifdef COLLISION_DETECT_EN
         , o_collision
`endif
  );
  modport slave (
    input  i_enable, i_blk_x, i_blk_y, i_blk_w, i_blk_h, i_blk_rgb, i_blk_valid,
           i_sq_y, i_sq_size, i_sq_rgb, i_bg_rgb,
    output o_h_sync, o_v_sync, o_rgb, o_frame_start
`ifdef COLLISION_DETECT_EN
         , o_collision
`endif
  );
endinterface

// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: VGA timing generator compositing blocks, a player square and background
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      vga_layer_compositor_if.slave (object inputs in, syncs/rgb/frame_start out)
// Object inputs are shadowed once per frame; output pixels lag the counters by 2 pixel ticks.
// Optional feature macro: COLLISION_DETECT_EN adds bus.o_collision, a per-frame flag that is
// set when the square overlapped any visible block during the previous frame.
module vga_layer_compositor #(
  parameter int NUM_BLOCKS = 4,
  parameter int COORD_W    = 10,
  parameter int RGB_W      = 12,
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SQUARE_X   = 100
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  vga_layer_compositor_if.slave bus
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W = $clog2(H_TOT > V_TOT ? H_TOT : V_TOT);
  // one spare bit so that X+W / Y+H never wrap
  localparam int E_W   = (CNT_W > COORD_W ? CNT_W : COORD_W) + 1;
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                    r_state;
  logic [1:0]                    w_state_nxt;
  logic [DIV_W-1:0]              r_div;
  logic [CNT_W-1:0]              r_hcnt;
  logic [CNT_W-1:0]              r_vcnt;
  logic [NUM_BLOCKS*COORD_W-1:0] r_blk_x;
  logic [NUM_BLOCKS*COORD_W-1:0] r_blk_y;
  logic [NUM_BLOCKS*COORD_W-1:0] r_blk_w;
  logic [NUM_BLOCKS*COORD_W-1:0] r_blk_h;
  logic [NUM_BLOCKS*RGB_W-1:0]   r_blk_rgb;
  logic [NUM_BLOCKS-1:0]         r_blk_valid;
  logic [COORD_W-1:0]            r_sq_y;
  logic [COORD_W-1:0]            r_sq_size;
  logic [RGB_W-1:0]              r_sq_rgb;
  logic [RGB_W-1:0]              r_bg_rgb;
  logic [NUM_BLOCKS-1:0]         r_s1_blk;
  logic                          r_s1_sq;
  logic                          r_s1_act;
  logic                          r_s1_hs;
  logic                          r_s1_vs;
  logic [RGB_W-1:0]              r_rgb;
  logic                          r_hs;
  logic                          r_vs;
  logic                          r_frame_start;
  logic                          w_tick;
  logic                          w_run;
  logic                          w_h_last;
  logic                          w_v_last;
  logic                          w_end;
  logic                          w_load;
  logic [E_W-1:0]                w_x;
  logic [E_W-1:0]                w_y;
  logic                          w_act;
  logic                          w_hs;
  logic                          w_vs;
  logic                          w_sq_hit;
  logic [NUM_BLOCKS-1:0]         w_blk_hit;
  logic [RGB_W-1:0]              w_pix;

  function automatic logic f_in(logic [E_W-1:0] p, logic [COORD_W-1:0] lo, logic [COORD_W-1:0] len);
    return p >= E_W'(lo) && p < E_W'(lo) + E_W'(len);
  endfunction

  assign w_tick   = r_div == DIV_W'(CLK_DIV - 1);
  assign w_run    = r_state != S_IDLE;
  assign w_h_last = r_hcnt == CNT_W'(H_TOT - 1);
  assign w_v_last = r_vcnt == CNT_W'(V_TOT - 1);
  assign w_end    = w_h_last && w_v_last;
  // a new frame starts on leaving IDLE, or at the wrap unless a drained frame is ending
  assign w_load   = w_tick && (w_run ? w_end && (r_state == S_RUN || bus.i_enable) : bus.i_enable);
  assign w_x      = E_W'(r_hcnt);
  assign w_y      = E_W'(r_vcnt);
  assign w_act    = w_run && w_x < E_W'(H_ACTIVE) && w_y < E_W'(V_ACTIVE);
  assign w_hs     = !(w_run && w_x >= E_W'(H_ACTIVE + H_FP) && w_x < E_W'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs     = !(w_run && w_y >= E_W'(V_ACTIVE + V_FP) && w_y < E_W'(V_ACTIVE + V_FP + V_SYNC));
  assign w_sq_hit = w_act && f_in(w_x, COORD_W'(SQUARE_X), r_sq_size) && f_in(w_y, r_sq_y, r_sq_size);

  always_comb begin
    w_state_nxt = r_state == S_IDLE ? (w_load ? S_RUN : S_IDLE)
                : bus.i_enable      ? S_RUN
                : r_state == S_RUN  ? S_DRAIN
                : (w_tick && w_end) ? S_IDLE : S_DRAIN;
  end

  always_comb begin
    w_blk_hit = '0;
    for (int i = 0; i < NUM_BLOCKS; i++)
      w_blk_hit[i] = w_act && r_blk_valid[i]
                  && f_in(w_x, r_blk_x[i*COORD_W +: COORD_W], r_blk_w[i*COORD_W +: COORD_W])
                  && f_in(w_y, r_blk_y[i*COORD_W +: COORD_W], r_blk_h[i*COORD_W +: COORD_W]);
  end

  // lowest-priority layer first so the higher ones overwrite it
  always_comb begin
    w_pix = r_bg_rgb;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--)
      w_pix = r_s1_blk[i] ? r_blk_rgb[i*RGB_W +: RGB_W] : w_pix;
    w_pix = r_s1_sq ? r_sq_rgb : w_pix;
    w_pix = r_s1_act ? w_pix : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_div         <= w_tick ? '0 : r_div + 1'b1;
      r_frame_start <= w_load;
      if (w_tick && w_run) begin
        r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
        r_vcnt <= w_h_last ? (w_v_last ? '0 : r_vcnt + 1'b1) : r_vcnt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blk_x     <= '0;
      r_blk_y     <= '0;
      r_blk_w     <= '0;
      r_blk_h     <= '0;
      r_blk_rgb   <= '0;
      r_blk_valid <= '0;
      r_sq_y      <= '0;
      r_sq_size   <= '0;
      r_sq_rgb    <= '0;
      r_bg_rgb    <= '0;
    end else if (w_load) begin
      r_blk_x     <= bus.i_blk_x;
      r_blk_y     <= bus.i_blk_y;
      r_blk_w     <= bus.i_blk_w;
      r_blk_h     <= bus.i_blk_h;
      r_blk_rgb   <= bus.i_blk_rgb;
      r_blk_valid <= bus.i_blk_valid;
      r_sq_y      <= bus.i_sq_y;
      r_sq_size   <= bus.i_sq_size;
      r_sq_rgb    <= bus.i_sq_rgb;
      r_bg_rgb    <= bus.i_bg_rgb;
    end
  end

  // the pipeline keeps ticking in IDLE so it flushes to blank/sync-high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_blk <= '0;
      r_s1_sq  <= 1'b0;
      r_s1_act <= 1'b0;
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
      r_rgb    <= '0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
    end else if (w_tick) begin
      r_s1_blk <= w_blk_hit;
      r_s1_sq  <= w_sq_hit;
      r_s1_act <= w_act;
      r_s1_hs  <= w_hs;
      r_s1_vs  <= w_vs;
      r_rgb    <= w_pix;
      r_hs     <= r_s1_hs;
      r_vs     <= r_s1_vs;
    end
  end

  assign bus.o_h_sync      = r_hs;
  assign bus.o_v_sync      = r_vs;
  assign bus.o_rgb         = r_rgb;
  assign bus.o_frame_start = r_frame_start;

`ifdef COLLISION_DETECT_EN
  logic r_coll_sticky;
  logic r_collision;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_coll_sticky <= 1'b0;
      r_collision   <= 1'b0;
    end else if (w_load) begin
      r_collision   <= r_coll_sticky;
      r_coll_sticky <= 1'b0;
    end else if (r_s1_sq && |r_s1_blk) begin
      r_coll_sticky <= 1'b1;
    end
  end

  assign bus.o_collision = r_collision;
`endif
endmodule

// File: tb/tb_vga_layer_compositor.sv
// tb_vga_layer_compositor: scoreboard bench for vga_layer_compositor on a reduced 40x35 raster
module tb_vga_layer_compositor;
  localparam int HT    = 40;
  localparam int VT    = 35;
  localparam int DIV   = 4;
  localparam int FRAME = HT * VT * DIV;

  typedef struct {
    int         key;
    logic [11:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   fcnt = 0;
  int   c = 0;
  int   cyc = 0;
  int   cur_key;
  logic fs_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  vga_layer_compositor_if #(.NUM_BLOCKS(4), .COORD_W(10), .RGB_W(12)) bus();

  vga_layer_compositor #(
    .NUM_BLOCKS(4), .COORD_W(10), .RGB_W(12), .CLK_DIV(DIV),
    .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(30), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SQUARE_X(20)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int f, input int x, input int y, input logic [11:0] rgb,
                      input logic hs, input logic vs);
    q.push_back('{f * 100000 + y * HT + x, rgb, hs, vs});
  endtask

  task automatic pa(input int f, input int x, input int y, input logic [11:0] rgb);
    push(f, x, y, rgb, 1'b1, 1'b1);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(output int f);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_frame_start && n < 8000);
    #1;
    check("frame_start_seen", bus.o_frame_start, 1);
    f = fcnt;
  endtask

  task automatic set_blk(input int i, input int x, input int y, input int w, input int h,
                         input logic [11:0] rgb);
    bus.i_blk_x[i*10 +: 10]   = 10'(x);
    bus.i_blk_y[i*10 +: 10]   = 10'(y);
    bus.i_blk_w[i*10 +: 10]   = 10'(w);
    bus.i_blk_h[i*10 +: 10]   = 10'(h);
    bus.i_blk_rgb[i*12 +: 12] = rgb;
  endtask

  // output pixel p of a frame is stable on negedges 8+4p .. 8+4p+3 after FRAME_START
  always @(negedge clk) begin
    if (fs_prev) check("frame_start_width", bus.o_frame_start, 0);
    fs_prev = bus.o_frame_start;
    if (bus.o_frame_start) begin
      fcnt++;
      c = 0;
    end else begin
      c++;
    end
    if (fcnt > 0 && c >= 8 && (c - 8) % 4 == 1) begin
      cur_key = fcnt * 100000 + (c - 8) / 4;
      while (q.size() > 0 && q[0].key < cur_key) begin
        check("pixel_missed_key", cur_key, q[0].key);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].key == cur_key) begin
        check($sformatf("rgb@%0d", cur_key), bus.o_rgb, q[0].rgb);
        check($sformatf("hsync@%0d", cur_key), bus.o_h_sync, q[0].hs);
        check($sformatf("vsync@%0d", cur_key), bus.o_v_sync, q[0].vs);
        void'(q.pop_front());
      end
    end
  end

  task automatic measure(input bit v, input string name, input int lo_req, input int per_req);
    int n = 0;
    int lo = 0;
    int per = 0;
    @(negedge clk);
    while ((v ? bus.o_v_sync : bus.o_h_sync) !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    while ((v ? bus.o_v_sync : bus.o_h_sync) !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    while ((v ? bus.o_v_sync : bus.o_h_sync) === 1'b0 && n < 20000) begin
      @(negedge clk); n++; lo++; per++;
    end
    while ((v ? bus.o_v_sync : bus.o_h_sync) === 1'b1 && n < 20000) begin
      @(negedge clk); n++; per++;
    end
    check({name, "_low_clks"}, lo, lo_req);
    check({name, "_period_clks"}, per, per_req);
  endtask

  initial begin : sync_meas
    wait (rst_n === 1'b1);
    measure(1'b0, "hsync", 4 * DIV, HT * DIV);
    measure(1'b1, "vsync", 2 * HT * DIV, FRAME);
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int f1, f2, f3, f4, f5, t4;
    bus.i_enable    = 1'b0;
    bus.i_blk_x     = '0;
    bus.i_blk_y     = '0;
    bus.i_blk_w     = '0;
    bus.i_blk_h     = '0;
    bus.i_blk_rgb   = '0;
    bus.i_blk_valid = '0;
    bus.i_sq_y      = '0;
    bus.i_sq_size   = '0;
    bus.i_sq_rgb    = '0;
    bus.i_bg_rgb    = '0;
    wait_clks(3);
    check("rst_hsync", bus.o_h_sync, 1);
    check("rst_vsync", bus.o_v_sync, 1);
    check("rst_rgb", bus.o_rgb, 0);
    check("rst_frame_start", bus.o_frame_start, 0);
`ifdef COLLISION_DETECT_EN
    check("rst_collision", bus.o_collision, 0);
`endif
    rst_n = 1'b1;
    // frame 1: block0 only; block1 covers everything but is not valid; block2 has W=0
    bus.i_bg_rgb = 12'h111;
    set_blk(0, 10, 20, 5, 5, 12'hF00);
    set_blk(1, 0, 0, 40, 40, 12'h0F0);
    set_blk(2, 0, 0, 0, 10, 12'h0FF);
    bus.i_blk_valid = 4'b0101;
    bus.i_enable = 1'b1;
    wait_frame(f1);
    pa(f1, 0, 0, 12'h111);
    push(f1, 32, 5, 12'h000, 1'b1, 1'b1);
    push(f1, 35, 5, 12'h000, 1'b0, 1'b1);
    pa(f1, 10, 20, 12'hF00);
    pa(f1, 14, 20, 12'hF00);
    pa(f1, 15, 20, 12'h111);
    pa(f1, 9, 22, 12'h111);
    pa(f1, 12, 22, 12'hF00);
    pa(f1, 10, 24, 12'hF00);
    pa(f1, 14, 24, 12'hF00);
    pa(f1, 10, 25, 12'h111);
    pa(f1, 31, 29, 12'h111);
    push(f1, 5, 31, 12'h000, 1'b1, 1'b0);
    push(f1, 35, 31, 12'h000, 1'b0, 1'b0);
    push(f1, 5, 33, 12'h000, 1'b1, 1'b1);
    // mid-frame change: moves block0 and adds square/block1 for frame 2 only
    wait_clks(15 * HT * DIV);
    set_blk(0, 18, 9, 4, 4, 12'hF00);
    set_blk(1, 19, 5, 10, 10, 12'h0F0);
    bus.i_blk_valid = 4'b0011;
    bus.i_sq_y = 10'd8;
    bus.i_sq_size = 10'd4;
    bus.i_sq_rgb = 12'h00F;
    wait_frame(f2);
`ifdef COLLISION_DETECT_EN
    check("collision_f2", bus.o_collision, 0);
`endif
    pa(f2, 22, 6, 12'h0F0);
    pa(f2, 18, 9, 12'hF00);
    pa(f2, 20, 10, 12'h00F);
    pa(f2, 23, 11, 12'h00F);
    pa(f2, 24, 11, 12'h0F0);
    pa(f2, 28, 14, 12'h0F0);
    pa(f2, 29, 14, 12'h111);
    pa(f2, 10, 20, 12'h111);
    wait_clks(15 * HT * DIV);
    bus.i_sq_size = 10'd0;
    wait_frame(f3);
`ifdef COLLISION_DETECT_EN
    check("collision_f3", bus.o_collision, 1);
`endif
    pa(f3, 20, 10, 12'hF00);
    pa(f3, 21, 12, 12'hF00);
    pa(f3, 22, 13, 12'h0F0);
    push(f3, 35, 31, 12'h000, 1'b0, 1'b0);
    push(f3, HT * VT + 35, 0, 12'h000, 1'b1, 1'b1);
    push(f3, HT * VT + 45, 0, 12'h000, 1'b1, 1'b1);
    // drain: frame 3 completes, then the scanner idles
    wait_clks(5 * HT * DIV);
    bus.i_enable = 1'b0;
    wait_clks(5400);
    check("idle_frame_count", fcnt, f3);
    bus.i_enable = 1'b1;
    wait_frame(f4);
`ifdef COLLISION_DETECT_EN
    check("collision_f4", bus.o_collision, 0);
`endif
    t4 = cyc;
    pa(f4, 5, 5, 12'h111);
    pa(f4, 20, 10, 12'hF00);
    // enable drops then returns within the frame: no gap before frame 5
    wait_clks(5 * HT * DIV);
    bus.i_enable = 1'b0;
    wait_clks(15 * HT * DIV);
    bus.i_enable = 1'b1;
    wait_frame(f5);
    check("drain_resume_gap_clks", cyc - t4, FRAME);
    pa(f5, 20, 10, 12'hF00);
    pa(f5, 15, 15, 12'h111);
    // asynchronous reset while pixel (16,15) is on the output
    wait_clks(8 + 4 * (15 * HT + 16) + 2);
    #1;
    check("pre_reset_rgb", bus.o_rgb, 12'h111);
    rst_n = 1'b0;
    #1;
    check("async_rst_hsync", bus.o_h_sync, 1);
    check("async_rst_vsync", bus.o_v_sync, 1);
    check("async_rst_rgb", bus.o_rgb, 0);
    check("async_rst_frame_start", bus.o_frame_start, 0);
`ifdef COLLISION_DETECT_EN
    check("async_rst_collision", bus.o_collision, 0);
`endif
    wait_clks(10);
    rst_n = 1'b1;
    wait_clks(4);
    check("scoreboard_left", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
